// File: rtl/channel_edge_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// channel_edge_meter - counts rising edges per channel over a gate window
//                      and streams one count per channel over valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module channel_edge_meter #(
  parameter int CHANNELS    = 5,
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    sig_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [2:0]             result_channel,
  output logic [COUNT_WIDTH-1:0] result_count,
  output logic                   result_overflow
);

  localparam int                     GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [2:0]             LAST_CH   = 3'(CHANNELS - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Input conditioning runs regardless of state so that stale edges are
  // already flushed through the pipeline when a gate opens.
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] sync_prev;
  logic [CHANNELS-1:0] edge_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      edge_hit  <= '0;
    end else begin
      sync1     <= sig_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      edge_hit  <= sync2 & ~sync_prev;
    end
  end

  logic [COUNT_WIDTH-1:0] count      [CHANNELS];
  logic [COUNT_WIDTH-1:0] count_next [CHANNELS];
  logic                   ovf        [CHANNELS];
  logic                   ovf_next   [CHANNELS];
  logic                   clear;
  logic                   counting;

  assign clear    = (state == IDLE) && start;
  assign counting = (state == GATE);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count_next[i] = count[i];
      ovf_next[i]   = ovf[i];
      if (clear) begin
        count_next[i] = '0;
        ovf_next[i]   = 1'b0;
      end else if (counting && edge_hit[i]) begin
        if (count[i] == COUNT_MAX) begin
          ovf_next[i] = 1'b1;
        end else begin
          count_next[i] = count[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= '0;
        ovf[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= count_next[i];
        ovf[i]   <= ovf_next[i];
      end
    end
  end

  // Zero-padded view so the 3-bit report index never selects outside the array.
  logic [COUNT_WIDTH-1:0] count_pad [8];
  logic                   ovf_pad   [8];

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < CHANNELS) begin : g_used
      assign count_pad[k] = count[k];
      assign ovf_pad[k]   = ovf[k];
    end else begin : g_unused
      assign count_pad[k] = '0;
      assign ovf_pad[k]   = 1'b0;
    end
  end

  logic [GW-1:0]          gate_cnt;
  logic [GW-1:0]          gate_cnt_next;
  logic                   busy_next;
  logic                   valid_next;
  logic [2:0]             chan_next;
  logic [2:0]             chan_inc;
  logic [COUNT_WIDTH-1:0] count_out_next;
  logic                   ovf_out_next;

  assign chan_inc = result_channel + 3'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      gate_cnt        <= '0;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      result_channel  <= 3'd0;
      result_count    <= '0;
      result_overflow <= 1'b0;
    end else begin
      state           <= state_next;
      gate_cnt        <= gate_cnt_next;
      busy            <= busy_next;
      result_valid    <= valid_next;
      result_channel  <= chan_next;
      result_count    <= count_out_next;
      result_overflow <= ovf_out_next;
    end
  end

  always_comb begin
    state_next     = state;
    gate_cnt_next  = gate_cnt;
    busy_next      = busy;
    valid_next     = result_valid;
    chan_next      = result_channel;
    count_out_next = result_count;
    ovf_out_next   = result_overflow;
    case (state)
      IDLE: begin
        if (start) begin
          state_next    = GATE;
          gate_cnt_next = '0;
          busy_next     = 1'b1;
        end
      end
      GATE: begin
        gate_cnt_next = gate_cnt + 1'b1;
        if (gate_cnt == GATE_LAST) begin
          // Channel 0 must include an edge landing on the final gate cycle.
          state_next     = REPORT;
          valid_next     = 1'b1;
          chan_next      = 3'd0;
          count_out_next = count_next[0];
          ovf_out_next   = ovf_next[0];
        end
      end
      REPORT: begin
        if (result_valid && result_ready) begin
          if (result_channel == LAST_CH) begin
            state_next     = IDLE;
            busy_next      = 1'b0;
            valid_next     = 1'b0;
            chan_next      = 3'd0;
            count_out_next = '0;
            ovf_out_next   = 1'b0;
          end else begin
            chan_next      = chan_inc;
            count_out_next = count_pad[chan_inc];
            ovf_out_next   = ovf_pad[chan_inc];
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_channel_edge_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_channel_edge_meter - directed bench for channel_edge_meter (gate = 20)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_channel_edge_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  sig_in;
  logic        start;
  logic        result_ready;

  logic        busy;
  logic        result_valid;
  logic [2:0]  result_channel;
  logic [15:0] result_count;
  logic        result_overflow;

  logic        sat_busy;
  logic        sat_valid;
  logic [2:0]  sat_channel;
  logic [2:0]  sat_count;
  logic        sat_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] wave [24];
  int         exp_cnt  [5];
  logic       exp_ovf  [5];
  int         exp_scnt [5];
  logic       exp_sovf [5];
  int         cyc;

  channel_edge_meter #(.CHANNELS(5), .GATE_CYCLES(20), .COUNT_WIDTH(16)) dut (
    .clock(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_channel(result_channel), .result_count(result_count),
    .result_overflow(result_overflow)
  );

  channel_edge_meter #(.CHANNELS(5), .GATE_CYCLES(20), .COUNT_WIDTH(3)) dut_sat (
    .clock(clk), .reset(reset), .sig_in(sig_in), .start(start),
    .busy(sat_busy), .result_valid(sat_valid), .result_ready(result_ready),
    .result_channel(sat_channel), .result_count(sat_count),
    .result_overflow(sat_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wave();
    for (int j = 0; j < 24; j++) wave[j] = '0;
  endtask

  // wave[j] is sampled at edge t-3+j, where t is the edge that samples start
  task automatic set_edge(input int ch, input int j);
    wave[j][ch] = 1'b1;
  endtask

  task automatic run_gate(input int mid_start);
    for (int j = 0; j < 24; j++) begin
      sig_in = wave[j];
      start  = (j == 3) || (j == mid_start);
      tick();
      if (j == 2)  check("busy_before_start", busy, 0);
      if (j == 3)  check("busy_after_start", busy, 1);
      if (j == 22) check("valid_before_gate_end", result_valid, 0);
      if (j == 23) begin
        check("first_valid", result_valid, 1);
        check("first_channel", result_channel, 0);
      end
    end
    start  = 1'b0;
    sig_in = '0;
  endtask

  task automatic collect(input int stall, input bit toggle, input int start_at,
                         input bit chk_sat, output int cycles);
    int          nxt;
    int          r;
    bit          stalled;
    logic [2:0]  hch;
    logic [15:0] hcnt;
    logic        hovf;
    nxt = 0; r = 0; stalled = 0; hch = '0; hcnt = '0; hovf = 1'b0;
    while (nxt < 5 && r < 100) begin
      check("valid_hold", result_valid, 1);
      if (stalled) begin
        check("stall_channel", result_channel, hch);
        check("stall_count", result_count, hcnt);
        check("stall_overflow", result_overflow, hovf);
      end
      if (r < stall)   result_ready = 1'b0;
      else if (toggle) result_ready = ((r - stall) % 2 == 0);
      else             result_ready = 1'b1;
      start = (r == start_at);
      if (result_ready) begin
        check("channel", result_channel, nxt);
        check("count", result_count, exp_cnt[nxt]);
        check("overflow", result_overflow, exp_ovf[nxt]);
        if (chk_sat) begin
          check("sat_channel", sat_channel, nxt);
          check("sat_count", sat_count, exp_scnt[nxt]);
          check("sat_overflow", sat_overflow, exp_sovf[nxt]);
        end
        nxt++;
        stalled = 0;
      end else begin
        stalled = 1;
        hch = result_channel; hcnt = result_count; hovf = result_overflow;
      end
      tick();
      r++;
    end
    check("report_done", nxt, 5);
    start = 1'b0;
    check("end_valid", result_valid, 0);
    check("end_busy", busy, 0);
    cycles = r;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_channel"}, result_channel, 0);
    check({tag, "_count"}, result_count, 0);
    check({tag, "_overflow"}, result_overflow, 0);
    check({tag, "_sat_busy"}, sat_busy, 0);
    check({tag, "_sat_valid"}, sat_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sig_in = '0; start = 1'b0; result_ready = 1'b1;
    tick(); tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick(); tick();

    // Basic count: channel 2 edges at gate cycles 4, 9, 14
    clear_wave();
    set_edge(2, 7); set_edge(2, 12); set_edge(2, 17);
    exp_cnt  = '{0, 0, 3, 0, 0};  exp_ovf  = '{0, 0, 0, 0, 0};
    exp_scnt = '{0, 0, 3, 0, 0};  exp_sovf = '{0, 0, 0, 0, 0};
    run_gate(-1);
    collect(0, 0, -1, 1, cyc);
    check("busy_drop_latency", cyc, 5);
    tick(); tick();

    // Saturation plus both window boundaries (t-2 counted, t+18 ignored)
    clear_wave();
    for (int j = 1; j <= 19; j += 2) set_edge(0, j);
    for (int j = 2; j <= 14; j += 2) set_edge(4, j);
    set_edge(1, 20);
    set_edge(3, 21);
    exp_cnt  = '{10, 1, 0, 0, 7};  exp_ovf  = '{0, 0, 0, 0, 0};
    exp_scnt = '{7, 1, 0, 0, 7};   exp_sovf = '{1, 0, 0, 0, 0};
    run_gate(-1);
    collect(0, 0, -1, 1, cyc);
    tick(); tick();

    // Backpressure: five stalled cycles then ready toggling
    result_ready = 1'b0;
    clear_wave();
    set_edge(0, 3); set_edge(0, 5); set_edge(4, 10);
    exp_cnt = '{2, 0, 0, 0, 1};  exp_ovf = '{0, 0, 0, 0, 0};
    run_gate(-1);
    collect(5, 1, -1, 0, cyc);
    check("backpressure_cycles", cyc, 14);
    tick(); tick();

    // Window: edges before start, extra starts mid-GATE and mid-REPORT
    for (int p = 0; p < 4; p++) begin
      sig_in = 5'b01000; tick();
      sig_in = 5'b00000; tick();
    end
    tick(); tick();
    result_ready = 1'b0;
    clear_wave();
    set_edge(1, 8);
    exp_cnt = '{0, 1, 0, 0, 0};  exp_ovf = '{0, 0, 0, 0, 0};
    run_gate(12);
    collect(2, 0, 1, 0, cyc);
    // Start on the very cycle busy has fallen
    start = 1'b1; tick(); start = 1'b0;
    check("restart_busy", busy, 1);
    for (int k = 1; k < 20; k++) tick();
    check("restart_valid_early", result_valid, 0);
    tick();
    check("restart_valid", result_valid, 1);
    exp_cnt = '{0, 0, 0, 0, 0};
    collect(0, 0, -1, 0, cyc);
    tick(); tick();

    // Reset in the middle of a gate discards the partial measurement
    result_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      sig_in = 5'b00010; tick();
      sig_in = 5'b00000; tick();
    end
    check("busy_mid_gate", busy, 1);
    reset = 1'b1; #1;
    check_zero("rst_gate");
    tick(); tick(); tick();
    reset = 1'b0;
    tick(); tick();
    clear_wave();
    set_edge(1, 5); set_edge(1, 10);
    exp_cnt = '{0, 2, 0, 0, 0};  exp_ovf = '{0, 0, 0, 0, 0};
    run_gate(-1);
    collect(0, 0, -1, 0, cyc);
    tick(); tick();

    // Reset while a result is being presented
    result_ready = 1'b0;
    clear_wave();
    set_edge(0, 5);
    run_gate(-1);
    check("pre_reset_count", result_count, 1);
    reset = 1'b1; #1;
    check_zero("rst_report");
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check_zero("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
